// File: rtl/i2s_rx_fifo.sv
// I2S / left-justified stereo receiver feeding a show-ahead frame FIFO.
// Latency: a frame is pushed 4 MCLK cycles after the BCLK rise carrying its last captured bit; VALID follows one cycle later.
// Backpressure: none toward the codec; a frame arriving while full with no pop is dropped and OVERFLOW latches.
//
// Ports:
//   MCLK     system clock, all logic runs here (>= 4x BCLK)
//   RESET    asynchronous active-low reset
//   BCLK     codec bit clock (asynchronous, oversampled)
//   LRCLK    codec frame clock, low = left slot, high = right slot
//   ADCDAT   codec serial data, MSB first
//   ENABLE   capture enable; low forces idle and flushes the FIFO
//   RD       pop request, ignored while VALID is low
//   LEFT     left sample of the oldest stored frame
//   RIGHT    right sample of the oldest stored frame
//   VALID    FIFO holds at least one frame
//   LEVEL    number of stored frames
//   OVERFLOW sticky flag: a frame was dropped
module i2s_rx_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  parameter int MODE   = 0
) (
  input  logic                     MCLK,
  input  logic                     RESET,
  input  logic                     BCLK,
  input  logic                     LRCLK,
  input  logic                     ADCDAT,
  input  logic                     ENABLE,
  input  logic                     RD,
  output logic [DATA_W-1:0]        LEFT,
  output logic [DATA_W-1:0]        RIGHT,
  output logic                     VALID,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW
);

  localparam int                AW   = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] MSB  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [AW:0]       FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  // ---------------------------------------------------------------
  // Input synchronisers and BCLK / LRCLK event detection
  // ---------------------------------------------------------------
  logic bclk_s1_q, bclk_s2_q, bclk_prev_q;
  logic lrck_s1_q, lrck_s2_q, lr_prev_q;
  logic adc_s1_q, adc_s2_q;
  logic bit_rise, lr_fall, lr_rise;

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      adc_s1_q    <= 1'b0;
      adc_s2_q    <= 1'b0;
      lr_prev_q   <= 1'b0;
    end else begin
      bclk_s1_q   <= BCLK;
      bclk_s2_q   <= bclk_s1_q;
      bclk_prev_q <= bclk_s2_q;
      lrck_s1_q   <= LRCLK;
      lrck_s2_q   <= lrck_s1_q;
      adc_s1_q    <= ADCDAT;
      adc_s2_q    <= adc_s1_q;
      // LRCLK is only meaningful as sampled on BCLK rises
      if (bit_rise) lr_prev_q <= lrck_s2_q;
    end
  end

  assign bit_rise = bclk_s2_q & ~bclk_prev_q;
  assign lr_fall  = bit_rise &  lr_prev_q & ~lrck_s2_q;
  assign lr_rise  = bit_rise & ~lr_prev_q &  lrck_s2_q;

  // ---------------------------------------------------------------
  // Slot FSM
  // ---------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, mask_q, left_q;
  logic              pushed_q;
  logic              slot_start, bit_take, latch_left, push;

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_SYNC;
      ST_SYNC:  if (lr_fall) state_d = ST_LEFT;
      ST_LEFT:  if (lr_rise) state_d = ST_RIGHT;
      ST_RIGHT: if (lr_fall) state_d = ST_LEFT;
      default:  state_d = ST_IDLE;
    endcase
    if (!ENABLE) state_d = ST_IDLE;
  end

  always_comb begin
    slot_start = 1'b0;
    bit_take   = 1'b0;
    latch_left = 1'b0;
    push       = 1'b0;
    if (ENABLE) begin
      case (state_q)
        ST_SYNC: slot_start = lr_fall;
        ST_LEFT: begin
          slot_start = lr_rise;
          latch_left = lr_rise;
          bit_take   = bit_rise & ~lr_rise;
        end
        ST_RIGHT: begin
          slot_start = lr_fall;
          bit_take   = bit_rise & ~lr_fall;
          // complete right word, or a short slot closed by the next left slot
          push       = ~pushed_q & ((mask_q == '0) | lr_fall);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Bit capture: one-hot mask walks MSB->LSB so a short slot leaves
  // the untouched LSBs at zero.
  // ---------------------------------------------------------------
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      sr_q     <= '0;
      mask_q   <= '0;
      left_q   <= '0;
      pushed_q <= 1'b0;
    end else begin
      if (slot_start) begin
        if (MODE == 1) begin
          sr_q   <= adc_s2_q ? MSB : '0;
          mask_q <= MSB >> 1;
        end else begin
          // Philips mode: the bit on the LRCLK-edge rise belongs to the old slot
          sr_q   <= '0;
          mask_q <= MSB;
        end
      end else if (bit_take && (mask_q != '0)) begin
        if (adc_s2_q) sr_q <= sr_q | mask_q;
        mask_q <= mask_q >> 1;
      end
      if (latch_left) left_q <= sr_q;
      if (slot_start)  pushed_q <= 1'b0;
      else if (push)   pushed_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Show-ahead frame FIFO
  // ---------------------------------------------------------------
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         level_q, level_d;
  logic                ovf_q;
  logic                pop, full, wr_en, ovf_set;
  logic [2*DATA_W-1:0] head;

  assign pop     = RD & VALID;
  assign full    = (level_q == FULL);
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge MCLK) begin
    if (wr_en) mem[wptr_q] <= {left_q, sr_q};
  end

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (!ENABLE) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_q | ovf_set;
    end
  end

  assign head     = mem[rptr_q];
  assign VALID    = (level_q != '0);
  // storage is not reset, so an empty FIFO presents zeros
  assign LEFT     = VALID ? head[2*DATA_W-1:DATA_W] : '0;
  assign RIGHT    = VALID ? head[DATA_W-1:0]        : '0;
  assign LEVEL    = level_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Bench for i2s_rx_fifo: one Philips-mode and one left-justified instance share the serial stream.
// A queue model decodes each slot from the bits actually sent and tracks FIFO contents per instance.
// Outputs are compared against the model on every quiet MCLK cycle, plus literal expectations.
module tb_i2s_rx_fifo;
  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int HALF  = 4;   // MCLK cycles per BCLK half period

  logic mclk = 1'b0, rst_n = 1'b0;
  logic bclk = 1'b0, lrclk = 1'b0, adcdat = 1'b0, enable = 1'b0;
  logic rd0 = 1'b0, rd1 = 1'b0;
  logic [DW-1:0] left0, right0, left1, right1;
  logic          valid0, valid1, ovf0, ovf1;
  logic [3:0]    level0, level1;

  always #5 mclk = ~mclk;

  i2s_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(0)) dut0 (
    .MCLK(mclk), .RESET(rst_n), .BCLK(bclk), .LRCLK(lrclk), .ADCDAT(adcdat),
    .ENABLE(enable), .RD(rd0), .LEFT(left0), .RIGHT(right0), .VALID(valid0),
    .LEVEL(level0), .OVERFLOW(ovf0));

  i2s_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(1)) dut1 (
    .MCLK(mclk), .RESET(rst_n), .BCLK(bclk), .LRCLK(lrclk), .ADCDAT(adcdat),
    .ENABLE(enable), .RD(rd1), .LEFT(left1), .RIGHT(right1), .VALID(valid1),
    .LEVEL(level1), .OVERFLOW(ovf1));

  // ---------------- model ----------------
  logic [2*DW-1:0] mq [2][$];
  bit              mov  [2];
  bit              pend [2];
  logic [2*DW-1:0] pfr  [2];
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // bits[k] is the ADCDAT value on the k-th BCLK rise of a slot (k=0 sees the LRCLK edge)
  function automatic logic [31:0] mkbits(input logic [31:0] val, input int nb, input bit lj);
    logic [31:0] b = '0;
    int off = lj ? 0 : 1;
    for (int k = 0; k < 32; k++)
      if (k >= off && k < off + nb) b[k] = val[nb-1-(k-off)];
    return b;
  endfunction

  function automatic logic [DW-1:0] decode(input logic [31:0] bits, input int s, input int m);
    logic [DW-1:0] v = '0;
    int off = (m == 0) ? 1 : 0;
    for (int j = 0; j < DW; j++)
      if (off + j < s) v[DW-1-j] = bits[off+j];
    return v;
  endfunction

  task automatic model_push(input int m, input logic [2*DW-1:0] fr, input bit pop_first);
    if (pop_first && mq[m].size() > 0) void'(mq[m].pop_front());
    if (mq[m].size() < DEPTH) mq[m].push_back(fr);
    else mov[m] = 1'b1;
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mov[m]  = 1'b0;
      pend[m] = 1'b0;
    end
  endtask

  task automatic chk_model(input int m);
    logic [DW-1:0]   l, r;
    logic            v, o;
    logic [3:0]      lv;
    logic [2*DW-1:0] h;
    if (m == 0) begin l = left0; r = right0; v = valid0; o = ovf0; lv = level0; end
    else        begin l = left1; r = right1; v = valid1; o = ovf1; lv = level1; end
    cmp($sformatf("d%0d.level", m), 32'(lv), mq[m].size());
    cmp($sformatf("d%0d.valid", m), 32'(v), 32'(mq[m].size() != 0));
    cmp($sformatf("d%0d.overflow", m), 32'(o), 32'(mov[m]));
    if (mq[m].size() != 0) begin
      h = mq[m][0];
      cmp($sformatf("d%0d.left", m), 32'(l), 32'(h[2*DW-1:DW]));
      cmp($sformatf("d%0d.right", m), 32'(r), 32'(h[DW-1:0]));
    end
  endtask

  always @(negedge mclk) begin
    if (chk_en && rst_n) begin
      chk_model(0);
      chk_model(1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_rise(input logic lr, input logic d);
    @(negedge mclk);
    bclk = 1'b0; lrclk = lr; adcdat = d;
    repeat (HALF-1) @(negedge mclk);
    @(negedge mclk);
    bclk = 1'b1;
  endtask

  // RD high exactly on the cycle the frame from the current rise is written
  task automatic pulse_rd(input int m);
    repeat (3) @(negedge mclk);
    if (m == 0) rd0 = 1'b1; else rd1 = 1'b1;
    @(negedge mclk);
    if (m == 0) rd0 = 1'b0; else rd1 = 1'b0;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    model_clear();
    @(negedge mclk);
    cmp("rst.d0.left", 32'(left0), 0);   cmp("rst.d0.right", 32'(right0), 0);
    cmp("rst.d0.valid", 32'(valid0), 0); cmp("rst.d0.level", 32'(level0), 0);
    cmp("rst.d0.ovf", 32'(ovf0), 0);
    cmp("rst.d1.left", 32'(left1), 0);   cmp("rst.d1.valid", 32'(valid1), 0);
    cmp("rst.d1.level", 32'(level1), 0);
    @(negedge mclk);
    rst_n = 1'b1;
  endtask

  task automatic settle_and_push_pending();
    repeat (4) @(negedge mclk);
    @(posedge mclk); #1;
    for (int m = 0; m < 2; m++)
      if (pend[m]) begin model_push(m, pfr[m], 1'b0); pend[m] = 1'b0; end
  endtask

  task automatic send_frame(input logic [31:0] lv, input logic [31:0] rv, input int nb,
                            input int s, input bit lj, input bit do_model, input bit rd_push,
                            input int en_k, input int rst_k);
    logic [31:0]   lb, rb;
    logic [DW-1:0] l, r;
    chk_en = 1'b0;
    lb = mkbits(lv, nb, lj);
    rb = mkbits(rv, nb, lj);
    if (lrclk == 1'b0)
      repeat (2) begin drive_rise(1'b1, 1'b0); repeat (HALF-1) @(negedge mclk); end
    for (int k = 0; k < s; k++) begin
      drive_rise(1'b0, lb[k]);
      if (k == rst_k) fork rst_pulse(); join_none
      repeat (HALF-1) @(negedge mclk);
    end
    for (int k = 0; k < s; k++) begin
      drive_rise(1'b1, rb[k]);
      if (k == en_k) enable = 1'b1;
      if (rd_push && k == DW)     fork pulse_rd(0); join_none
      if (rd_push && k == DW - 1) fork pulse_rd(1); join_none
      repeat (HALF-1) @(negedge mclk);
    end
    settle_and_push_pending();
    if (do_model) begin
      for (int m = 0; m < 2; m++) begin
        l = decode(lb, s, m);
        r = decode(rb, s, m);
        if (((m == 0) ? 1 : 0) + DW <= s) model_push(m, {l, r}, rd_push);
        else begin pend[m] = 1'b1; pfr[m] = {l, r}; end
      end
    end
    chk_en = 1'b1;
  endtask

  task automatic frame24(input logic [23:0] l, input logic [23:0] r);
    send_frame(32'(l), 32'(r), 24, 32, 1'b0, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic pop_both();
    @(negedge mclk);
    rd0 = 1'b1; rd1 = 1'b1;
    @(posedge mclk); #1;
    for (int m = 0; m < 2; m++) if (mq[m].size() > 0) void'(mq[m].pop_front());
    @(negedge mclk);
    rd0 = 1'b0; rd1 = 1'b0;
  endtask

  task automatic flush(input bit keep_low);
    @(negedge mclk);
    enable = 1'b0;
    @(posedge mclk); #1;
    model_clear();
    repeat (2) @(negedge mclk);
    if (!keep_low) enable = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [23:0] nv;
    model_clear();
    repeat (3) @(negedge mclk);
    cmp("reset.level", 32'(level0), 0);
    cmp("reset.valid", 32'(valid0), 0);
    cmp("reset.overflow", 32'(ovf0), 0);
    cmp("reset.left", 32'(left0), 0);
    cmp("reset.right", 32'(right0), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    chk_en = 1'b1;

    // Philips stream, 32-bit slots
    frame24(24'hA5A5A5, 24'h5A5A5A);
    @(negedge mclk);
    cmp("i2s.left", 32'(left0), 32'hA5A5A5);
    cmp("i2s.right", 32'(right0), 32'h5A5A5A);
    cmp("i2s.valid", 32'(valid0), 1);
    cmp("i2s.level", 32'(level0), 1);
    cmp("i2s_in_lj.left", 32'(left1), 32'h52D2D2);

    // left-justified stream
    send_frame(32'hA5A5A5, 32'h5A5A5A, 24, 32, 1'b1, 1'b1, 1'b0, -1, -1);
    pop_both();
    @(negedge mclk);
    cmp("lj.left", 32'(left1), 32'hA5A5A5);
    cmp("lj.right", 32'(right1), 32'h5A5A5A);

    // overflow: nine frames, no reads
    flush(1'b0);
    for (int n = 1; n <= 9; n++) begin
      nv = 24'(n);
      frame24(nv, ~nv);
    end
    @(negedge mclk);
    cmp("ovf.level", 32'(level0), 8);
    cmp("ovf.flag", 32'(ovf0), 1);
    cmp("ovf.head", 32'(left0), 1);
    for (int n = 1; n <= 8; n++) begin
      @(negedge mclk);
      cmp($sformatf("drain.left%0d", n), 32'(left0), n);
      pop_both();
    end
    @(negedge mclk);
    cmp("drain.valid", 32'(valid0), 0);

    // push and pop together while full
    flush(1'b0);
    for (int n = 1; n <= 8; n++) begin
      nv = 24'(n);
      frame24(nv, ~nv);
    end
    send_frame(32'd9, 32'hFFFFF6, 24, 32, 1'b0, 1'b1, 1'b1, -1, -1);
    @(negedge mclk);
    cmp("fullrw.level", 32'(level0), 8);
    cmp("fullrw.ovf", 32'(ovf0), 0);
    cmp("fullrw.head", 32'(left0), 2);
    repeat (7) pop_both();
    @(negedge mclk);
    cmp("fullrw.last.left", 32'(left0), 9);
    cmp("fullrw.last.right", 32'(right0), 32'hFFFFF6);

    // enable raised mid right slot: that frame is not captured
    flush(1'b1);
    send_frame(32'h111111, 32'h222222, 24, 32, 1'b0, 1'b0, 1'b0, 10, -1);
    frame24(24'h333333, 24'h444444);
    @(negedge mclk);
    cmp("en_mid.level", 32'(level0), 1);
    cmp("en_mid.left", 32'(left0), 32'h333333);
    cmp("en_mid.right", 32'(right0), 32'h444444);

    // reset mid left slot: nothing until the next left slot starts
    send_frame(32'h555555, 32'h666666, 24, 32, 1'b0, 1'b0, 1'b0, -1, 5);
    frame24(24'h777777, 24'h888888);
    @(negedge mclk);
    cmp("rst_mid.level", 32'(level0), 1);
    cmp("rst_mid.left", 32'(left0), 32'h777777);
    pop_both();

    // 16-bit slots, left-justified: short words are zero-filled
    send_frame(32'hBEEF, 32'hCAFE, 16, 16, 1'b1, 1'b1, 1'b0, -1, -1);
    chk_en = 1'b0;
    drive_rise(1'b0, 1'b0);
    repeat (HALF-1) @(negedge mclk);
    settle_and_push_pending();
    chk_en = 1'b1;
    @(negedge mclk);
    cmp("short.left", 32'(left1), 32'hBEEF00);
    cmp("short.right", 32'(right1), 32'hCAFE00);
    cmp("short.level", 32'(level1), 1);

    repeat (4) @(negedge mclk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2s_rx_fifo.md
I2S_RX_FIFO -- requirements
Module: i2s_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, captured sample width per channel (8..32).
REQ-002 The block SHALL have parameter DEPTH, default 8, FIFO depth in stereo frames (power of 2, >=2).
REQ-003 The block SHALL have parameter MODE, default 0, where 0 = Philips I2S (one-BCLK MSB delay) and 1 = left-justified (no delay).
REQ-004 The block SHALL have port MCLK  in  1  system clock; all logic is in this single domain, and MCLK SHALL be >= 4x BCLK.
REQ-005 The block SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port BCLK  in  1  codec bit clock, asynchronous, oversampled.
REQ-007 The block SHALL have port LRCLK  in  1  codec ADC frame clock, where low = left and high = right.
REQ-008 The block SHALL have port ADCDAT  in  1  codec serial data, MSB first.
REQ-009 The block SHALL have port ENABLE  in  1  capture enable; low means idle plus flush.
REQ-010 The block SHALL have port RD  in  1  pop request from the consumer.
REQ-011 The block SHALL have port LEFT  out  DATA_W  left sample at the FIFO head.
REQ-012 The block SHALL have port RIGHT  out  DATA_W  right sample at the FIFO head.
REQ-013 The block SHALL have port VALID  out  1  FIFO non-empty; head data is valid.
REQ-014 The block SHALL have port LEVEL  out  clog2(DEPTH)+1  number of stored frames.
REQ-015 The block SHALL have port OVERFLOW  out  1  sticky flag set when a frame was dropped.

Function
REQ-016 The block SHALL pass BCLK, LRCLK and ADCDAT through 2-flop synchronisers, then detect BCLK rising edges with a 1-cycle registered compare; all bit and frame events occur only on a detected BCLK rise.
REQ-017 The block SHALL detect an LRCLK transition as a change of synchronised LRCLK versus its value at the previous BCLK rise.
REQ-018 The block SHALL implement FSM states IDLE, SYNC, LEFT, RIGHT.
REQ-019 In any state, ENABLE=0 SHALL force IDLE; the partial frame is discarded.
REQ-020 IDLE -> SYNC SHALL occur on ENABLE=1.
REQ-021 SYNC -> LEFT SHALL occur only on an LRCLK 1->0 transition, so the first captured frame is always complete and left-first.
REQ-022 LEFT -> RIGHT SHALL occur on an LRCLK 0->1 transition, and RIGHT -> LEFT on an LRCLK 1->0 transition.
REQ-023 With MODE=0, the bit on the first BCLK rise after a transition SHALL be ignored and the MSB taken on the second rise; with MODE=1, the MSB SHALL be taken on the first rise.
REQ-024 The block SHALL shift DATA_W bits MSB first per channel and ignore further bits in the slot.
REQ-025 If the slot ends before DATA_W bits are captured, the received bits SHALL be left-aligned and the LSBs zero-filled.
REQ-026 The {left,right} frame SHALL be pushed on the MCLK cycle after the DATA_W-th right bit is shifted, or on the RIGHT->LEFT transition if the right slot is short, exactly once per frame.
REQ-027 The FIFO SHALL be show-ahead: VALID=1 when LEVEL>0, and LEFT/RIGHT SHALL show the oldest frame combinationally from storage.
REQ-028 A pop SHALL occur when RD=1 and VALID=1; RD with VALID=0 SHALL be ignored.
REQ-029 VALID SHALL rise on the MCLK cycle after the push into an empty FIFO.
REQ-030 A push when LEVEL=DEPTH and no pop SHALL drop the new frame, leave contents unchanged and set OVERFLOW.
REQ-031 A push and a pop in the same cycle SHALL both be accepted, including at full, with LEVEL unchanged.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 ENABLE=0 SHALL flush the FIFO, setting LEVEL to 0, and clear OVERFLOW in the same cycle.

Reset
REQ-034 RESET=0 SHALL asynchronously set the FSM to IDLE; LEVEL, pointers, shift registers, synchronisers, OVERFLOW, VALID, LEFT and RIGHT SHALL be 0.
REQ-035 After RESET deasserts, the block SHALL behave as if ENABLE had just been sampled.

Verification
REQ-036 DATA_W=24, MODE=0, 32-bit slots, send L=0xA5A5A5 and R=0x5A5A5A -> LEFT=0xA5A5A5, RIGHT=0x5A5A5A, VALID=1, LEVEL=1.
REQ-037 Same data with MODE=1 and the stream without the 1-bit delay -> identical outputs; the MODE=0 stream fed to MODE=1 -> LEFT=0x52D2D2.
REQ-038 DEPTH=8, 9 frames (L=n, R=~n) with RD=0 -> LEVEL=8, OVERFLOW=1, head L=1; 8 pops -> L=1..8 in order, then VALID=0.
REQ-039 FIFO full with RD=1 held on the push cycle -> LEVEL stays 8, OVERFLOW stays 0, and the new frame appears last.
REQ-040 ENABLE raised mid right slot -> that frame is ignored and the first push is the next full frame; RESET pulsed mid left slot -> all outputs 0 and no push until the next LRCLK 1->0.
REQ-041 16-bit slots with DATA_W=24, L bits 0xBEEF -> LEFT=0xBEEF00.
